coil_scheduler: RTL and testbench

- Multi-channel ignition coil scheduler driven by the angle generator's main angle counter.
- Each channel raises its coil output at a programmed on-angle (dwell start) and drops it at a programmed off-angle (spark).
- Angle configuration is written into shadow registers and committed only at revolution boundaries, so updates never glitch a running dwell.
- Enforces a hard maximum dwell time per channel and reports overruns as sticky faults.

---
 rtl/hwag_pkg.sv | 17 +
 rtl/coil_channel.sv | 123 ++++++++++++
 rtl/coil_scheduler.sv | 63 ++++++
 tb/tb_coil_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared types and constants for the angle-driven coil scheduling blocks.
package hwag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } ch_state_t;

    localparam int ANGLE_W = 16;
    localparam logic [ANGLE_W-1:0] ANGLE_TOP = 16'd3839;

    localparam logic CFG_ON  = 1'b0;
    localparam logic CFG_OFF = 1'b1;

endpackage

// File: rtl/coil_channel.sv
// One ignition coil channel: shadowed on/off angles, dwell FSM,
// max-dwell guard and sticky fault.
module coil_channel
    import hwag_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 24,
    parameter logic [DW-1:0] MAX_DWELL = 24'd160000,
    parameter logic [AW-1:0] ANGLE_TOP = 16'd3839
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hwag_start,
    input  logic          en,
    input  logic [AW-1:0] angle,
    input  logic          angle_upd,
    input  logic          rev_start,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [AW-1:0] cfg_data,
    input  logic          fault_clr,
    output logic          coil,
    output logic          fault,
    output logic          armed
);

    ch_state_t     state, state_n;
    logic [AW-1:0] on_sh, off_sh;
    logic [AW-1:0] on_act, off_act;
    logic [AW-1:0] on_eff, off_eff;
    logic [DW-1:0] timer, timer_n;
    logic          wrapped, wrapped_n;
    logic          commit, commit_rev;
    logic          fault_set;
    logic          live, in_range, on_hit, off_hit, at_max;

    // Revolution commit is visible to this cycle's match and liveness.
    assign commit_rev = rev_start && (state != DWELL);
    assign on_eff     = commit_rev ? on_sh  : on_act;
    assign off_eff    = commit_rev ? off_sh : off_act;

    assign live     = hwag_start && en && (on_eff != off_eff);
    assign in_range = angle <= ANGLE_TOP;
    assign on_hit   = angle_upd && in_range && (angle == on_eff);
    assign off_hit  = angle_upd && in_range && (angle == off_eff);
    assign at_max   = timer == MAX_DWELL - 1'b1;

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        wrapped_n = wrapped;
        commit    = commit_rev;
        fault_set = 1'b0;
        if (!live) begin
            state_n   = IDLE;
            timer_n   = '0;
            wrapped_n = 1'b0;
            commit    = commit_rev || (state == DWELL);
        end else begin
            unique case (state)
                IDLE: begin
                    if (rev_start) state_n = ARMED;
                end
                ARMED: begin
                    if (on_hit) begin
                        state_n = DWELL;
                        timer_n = '0;
                    end
                end
                DWELL: begin
                    if (!at_max) timer_n = timer + 1'b1;
                    if (rev_start) begin
                        wrapped_n = 1'b1;
                    end else if (off_hit) begin
                        state_n   = wrapped ? ARMED : DONE;
                        wrapped_n = 1'b0;
                        commit    = 1'b1;
                    end else if (at_max) begin
                        state_n   = DONE;
                        wrapped_n = 1'b0;
                        commit    = 1'b1;
                        fault_set = 1'b1;
                    end
                end
                DONE: begin
                    if (rev_start) state_n = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            wrapped <= 1'b0;
            on_sh   <= '0;
            off_sh  <= '0;
            on_act  <= '0;
            off_act <= '0;
            coil    <= 1'b0;
            armed   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            wrapped <= wrapped_n;
            coil    <= state_n == DWELL;
            armed   <= state_n == ARMED;
            if (fault_set) fault <= 1'b1;
            else if (fault_clr) fault <= 1'b0;
            if (commit) begin
                on_act  <= on_sh;
                off_act <= off_sh;
            end
            if (cfg_we) begin
                if (cfg_sel == CFG_ON) on_sh <= cfg_data;
                else off_sh <= cfg_data;
            end
        end
    end

endmodule

// File: rtl/coil_scheduler.sv
// Multi-channel ignition coil scheduler: decodes shadow writes and
// fans the angle stream out to one coil_channel per coil.
module coil_scheduler
    import hwag_pkg::*;
#(
    parameter int CH = 4,
    parameter int AW = 16,
    parameter int DW = 24,
    parameter logic [DW-1:0] MAX_DWELL = 24'd160000,
    parameter logic [AW-1:0] ANGLE_TOP = 16'd3839
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hwag_start,
    input  logic [AW-1:0]         angle,
    input  logic                  angle_upd,
    input  logic                  rev_start,
    input  logic                  cfg_we,
    input  logic [$clog2(CH)-1:0] cfg_ch,
    input  logic                  cfg_sel,
    input  logic [AW-1:0]         cfg_data,
    input  logic [CH-1:0]         ch_en,
    input  logic [CH-1:0]         fault_clr,
    output logic [CH-1:0]         coil,
    output logic [CH-1:0]         fault,
    output logic [CH-1:0]         armed
);

    logic [CH-1:0] ch_we;

    // Out-of-range channel numbers decode to no write at all.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CH; i++) begin
            ch_we[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        coil_channel #(
            .AW(AW),
            .DW(DW),
            .MAX_DWELL(MAX_DWELL),
            .ANGLE_TOP(ANGLE_TOP)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .hwag_start(hwag_start),
            .en(ch_en[i]),
            .angle(angle),
            .angle_upd(angle_upd),
            .rev_start(rev_start),
            .cfg_we(ch_we[i]),
            .cfg_sel(cfg_sel),
            .cfg_data(cfg_data),
            .fault_clr(fault_clr[i]),
            .coil(coil[i]),
            .fault(fault[i]),
            .armed(armed[i])
        );
    end

endmodule

// File: tb/tb_coil_scheduler.sv
// Directed bench for coil_scheduler: windows, wrap, max dwell,
// shadow commit, sync loss and commit/write collision.
module tb_coil_scheduler;

    localparam int CH = 4;
    localparam int AW = 16;
    localparam int DW = 24;
    localparam logic [DW-1:0] MAXD = 24'd600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hwag_start = 1'b0;
    logic [AW-1:0] angle = '0;
    logic          angle_upd = 1'b0;
    logic          rev_start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic          cfg_sel = 1'b0;
    logic [AW-1:0] cfg_data = '0;
    logic [CH-1:0] ch_en = '0;
    logic [CH-1:0] fault_clr = '0;
    logic [CH-1:0] coil, fault, armed;

    int total = 0;
    int bad = 0;

    coil_scheduler #(
        .CH(CH), .AW(AW), .DW(DW),
        .MAX_DWELL(MAXD), .ANGLE_TOP(16'd3839)
    ) dut (
        .clk(clk), .rst(rst), .hwag_start(hwag_start),
        .angle(angle), .angle_upd(angle_upd), .rev_start(rev_start),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .ch_en(ch_en), .fault_clr(fault_clr),
        .coil(coil), .fault(fault), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three idle clocks, then one angle_upd cycle; returns just after it.
    task automatic step(input logic [AW-1:0] a, input logic rs);
        repeat (3) tick();
        angle = a;
        angle_upd = 1'b1;
        rev_start = rs;
        tick();
        angle_upd = 1'b0;
        rev_start = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic sel,
                       input logic [AW-1:0] d);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_sel = sel;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({coil, fault, armed} !== 12'h000) begin
            bad++;
            $display("FAIL reset coil=%b fault=%b armed=%b exp 0",
                     coil, fault, armed);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [CH-1:0] e;
        hwag_start = 1'b1;
        ch_en = 4'b0001;
        cfg(2'd0, 1'b0, 16'd1000);
        cfg(2'd0, 1'b1, 16'd900);
        total++;
        if (armed !== 4'b0000) begin
            bad++;
            $display("FAIL basic_pre_armed got=%b exp=0000", armed);
        end
        step(16'd3839, 1'b1);
        total++;
        if (armed !== 4'b0001) begin
            bad++;
            $display("FAIL basic_arm got=%b exp=0001", armed);
        end
        for (int a = 1003; a >= 897; a--) begin
            step(AW'(a), 1'b0);
            e = {3'b000, (a <= 1000) && (a > 900)};
            total++;
            if (coil !== e) begin
                bad++;
                $display("FAIL basic_coil angle=%0d got=%b exp=%b", a, coil, e);
            end
        end
        total++;
        if (armed !== 4'b0000 || fault !== 4'b0000) begin
            bad++;
            $display("FAIL basic_done armed=%b fault=%b exp 0000/0000",
                     armed, fault);
        end
        step(16'd3839, 1'b1);
        total++;
        if (armed !== 4'b0001) begin
            bad++;
            $display("FAIL basic_rearm got=%b exp=0001", armed);
        end
    endtask

    task automatic test_wrap();
        logic [CH-1:0] e;
        cfg(2'd0, 1'b0, 16'd20);
        cfg(2'd0, 1'b1, 16'd3800);
        step(16'd3839, 1'b1);
        step(16'd21, 1'b0);
        total++;
        if (coil !== 4'b0000) begin
            bad++;
            $display("FAIL wrap_pre got=%b exp=0000", coil);
        end
        step(16'd20, 1'b0);
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_rise got=%b exp=0001", coil);
        end
        step(16'd0, 1'b0);
        step(16'd3839, 1'b1);
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_across_top got=%b exp=0001", coil);
        end
        for (int a = 3838; a >= 3799; a--) begin
            step(AW'(a), 1'b0);
            e = {3'b000, a > 3800};
            total++;
            if (coil !== e) begin
                bad++;
                $display("FAIL wrap_coil angle=%0d got=%b exp=%b", a, coil, e);
            end
        end
        total++;
        if (armed !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_rearm got=%b exp=0001", armed);
        end
        step(16'd21, 1'b0);
        step(16'd20, 1'b0);
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_refire got=%b exp=0001", coil);
        end
    endtask

    task automatic test_hwag_drop();
        hwag_start = 1'b0;
        tick();
        total++;
        if ({coil, armed, fault} !== 12'h000) begin
            bad++;
            $display("FAIL drop coil=%b armed=%b fault=%b exp 0",
                     coil, armed, fault);
        end
        hwag_start = 1'b1;
        step(16'd20, 1'b0);
        total++;
        if (coil !== 4'b0000 || armed !== 4'b0000) begin
            bad++;
            $display("FAIL drop_nofire coil=%b armed=%b exp 0000/0000",
                     coil, armed);
        end
        step(16'd3839, 1'b1);
        total++;
        if (armed !== 4'b0001 || coil !== 4'b0000) begin
            bad++;
            $display("FAIL drop_rearm armed=%b coil=%b exp 0001/0000",
                     armed, coil);
        end
    endtask

    task automatic test_max_dwell();
        cfg(2'd0, 1'b0, 16'd1000);
        cfg(2'd0, 1'b1, 16'd100);
        step(16'd3839, 1'b1);
        step(16'd1000, 1'b0);
        repeat (int'(MAXD) - 1) tick();
        total++;
        if (coil !== 4'b0001 || fault !== 4'b0000) begin
            bad++;
            $display("FAIL maxd_last coil=%b fault=%b exp 0001/0000",
                     coil, fault);
        end
        tick();
        total++;
        if (coil !== 4'b0000 || fault !== 4'b0001 || armed !== 4'b0000) begin
            bad++;
            $display("FAIL maxd_trip coil=%b fault=%b armed=%b exp 0/1/0",
                     coil, fault, armed);
        end
        repeat (5) tick();
        total++;
        if (fault !== 4'b0001) begin
            bad++;
            $display("FAIL maxd_sticky got=%b exp=0001", fault);
        end
        fault_clr = 4'b0001;
        tick();
        fault_clr = 4'b0000;
        total++;
        if (fault !== 4'b0000) begin
            bad++;
            $display("FAIL maxd_clear got=%b exp=0000", fault);
        end
    endtask

    task automatic test_shadow();
        cfg(2'd0, 1'b0, 16'd1000);
        cfg(2'd0, 1'b1, 16'd900);
        step(16'd3839, 1'b1);
        step(16'd1000, 1'b0);
        cfg(2'd0, 1'b1, 16'd500);
        step(16'd901, 1'b0);
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL shadow_hold got=%b exp=0001", coil);
        end
        step(16'd900, 1'b0);
        total++;
        if (coil !== 4'b0000 || armed !== 4'b0000) begin
            bad++;
            $display("FAIL shadow_old_off coil=%b armed=%b exp 0000/0000",
                     coil, armed);
        end
        step(16'd3839, 1'b1);
        step(16'd1000, 1'b0);
        step(16'd900, 1'b0);
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL shadow_skip_900 got=%b exp=0001", coil);
        end
        step(16'd500, 1'b0);
        total++;
        if (coil !== 4'b0000) begin
            bad++;
            $display("FAIL shadow_new_off got=%b exp=0000", coil);
        end
    endtask

    task automatic test_commit_collision();
        cfg(2'd0, 1'b0, 16'd3839);
        cfg(2'd0, 1'b1, 16'd2000);
        step(16'd3839, 1'b1);
        step(16'd3000, 1'b0);
        step(16'd2000, 1'b0);
        total++;
        if (armed !== 4'b0001 || coil !== 4'b0000) begin
            bad++;
            $display("FAIL coll_armed armed=%b coil=%b exp 0001/0000",
                     armed, coil);
        end
        repeat (3) tick();
        angle = 16'd3839;
        angle_upd = 1'b1;
        rev_start = 1'b1;
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_sel = 1'b0;
        cfg_data = 16'd100;
        tick();
        angle_upd = 1'b0;
        rev_start = 1'b0;
        cfg_we = 1'b0;
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL coll_top_match got=%b exp=0001", coil);
        end
        step(16'd2000, 1'b0);
        total++;
        if (coil !== 4'b0000 || armed !== 4'b0000) begin
            bad++;
            $display("FAIL coll_off coil=%b armed=%b exp 0000/0000",
                     coil, armed);
        end
        step(16'd3839, 1'b1);
        step(16'd100, 1'b0);
        total++;
        if (coil !== 4'b0001) begin
            bad++;
            $display("FAIL coll_new_on got=%b exp=0001", coil);
        end
        step(16'd2000, 1'b0);
        total++;
        if (coil !== 4'b0000) begin
            bad++;
            $display("FAIL coll_end got=%b exp=0000", coil);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_hwag_drop();
        test_max_dwell();
        test_shadow();
        test_commit_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
